aes_key_expand_ctrl: RTL and testbench

//   Sequences the single-round AES-128 key schedule step through rounds 1..NR. Stores all NR+1

---
 rtl/aes_pkg.sv | 17 +
 rtl/aes_rkey_store.sv | 43 ++++
 rtl/aes_key_expand_ctrl.sv | 126 ++++++++++++
 tb/tb_aes_key_expand_ctrl.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-expansion types: round count, key width, FSM state encoding and round index.
// Imported by the key-expansion controller and its round-key store.
package aes_pkg;
  localparam int AES_NR      = 10;
  localparam int AES_KEY_W   = 128;
  localparam int AES_TIMEOUT = 15;

  typedef logic [3:0] round_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_GAP,
    ST_FIN
  } state_e;
endpackage

// File: rtl/aes_rkey_store.sv
// (NR+1) x KEY_W round-key register file: one write port, one registered read port (1-cycle latency).
// Reads are valid only below keys_ready as sampled at the request cycle; no backpressure, invalid reads return 0.
module aes_rkey_store
  import aes_pkg::*;
#(
  parameter int NR    = AES_NR,
  parameter int KEY_W = AES_KEY_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  round_t           waddr,
  input  logic [KEY_W-1:0] wdata,
  input  round_t           keys_ready,
  input  logic             rd_en,
  input  round_t           rd_round,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid
);

  logic [KEY_W-1:0] mem [NR+1];
  logic             rd_hit;
  round_t           rd_idx;

  // keys_ready acts as the valid mask: entries below it hold keys of the current expansion
  always_comb begin
    rd_hit = rd_en && (rd_round < keys_ready) && (int'(rd_round) <= NR);
    rd_idx = (int'(rd_round) <= NR) ? rd_round : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NR; i++) mem[i] <= '0;
      rd_key   <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (we && (int'(waddr) <= NR)) mem[waddr] <= wdata;
      rd_valid <= rd_hit;
      rd_key   <= rd_hit ? mem[rd_idx] : '0;
    end
  end

endmodule

// File: rtl/aes_key_expand_ctrl.sv
// Sequences the external AES-128 key-schedule step through rounds 1..NR and buffers every round key.
// Start-to-done is 3*NR cycles with a 1-cycle step; a missing ks_done aborts after TIMEOUT wait cycles.
module aes_key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NR      = AES_NR,
  parameter int KEY_W   = AES_KEY_W,
  parameter int TIMEOUT = AES_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [KEY_W-1:0] key_in,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [3:0]       keys_ready,
  output logic             ks_ena,
  output logic [3:0]       ks_round,
  output logic [KEY_W-1:0] ks_prev_key,
  input  logic [KEY_W-1:0] ks_next_key,
  input  logic             ks_done,
  input  logic             rd_en,
  input  logic [3:0]       rd_round,
  output logic [KEY_W-1:0] rd_key,
  output logic             rd_valid
);

  localparam int     TW   = $clog2(TIMEOUT + 1);
  localparam round_t LAST = round_t'(NR);

  state_e           state, state_nxt;
  round_t           round_q, keys_ready_q;
  logic [TW-1:0]    tmo_q;
  logic             err_q;
  logic [KEY_W-1:0] prev_q;
  logic             start_acc, store, tmo_hit;
  logic             st_we;
  round_t           st_waddr;
  logic [KEY_W-1:0] st_wdata;

  always_comb begin
    state_nxt = state;
    start_acc = 1'b0;
    store     = 1'b0;
    tmo_hit   = 1'b0;
    if (abort) begin
      state_nxt = ST_IDLE;
    end else begin
      unique case (state)
        ST_IDLE: if (start) begin
          start_acc = 1'b1;
          state_nxt = ST_REQ;
        end
        ST_REQ:  state_nxt = ST_WAIT;
        ST_WAIT: if (ks_done) begin
          store     = 1'b1;
          state_nxt = (round_q == LAST) ? ST_FIN : ST_GAP;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          tmo_hit   = 1'b1;
          state_nxt = ST_IDLE;
        end
        // one idle cycle lets a level-style ks_done fall before the next request
        ST_GAP:  state_nxt = ST_REQ;
        ST_FIN:  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      round_q      <= '0;
      keys_ready_q <= '0;
      tmo_q        <= '0;
      err_q        <= 1'b0;
      prev_q       <= '0;
    end else begin
      state <= state_nxt;
      if (abort) begin
        keys_ready_q <= '0;
      end else if (start_acc) begin
        round_q      <= round_t'(1);
        keys_ready_q <= round_t'(1);
        err_q        <= 1'b0;
        prev_q       <= key_in;
      end else if (store) begin
        keys_ready_q <= round_q + round_t'(1);
        prev_q       <= ks_next_key;
        if (round_q != LAST) round_q <= round_q + round_t'(1);
      end else if (tmo_hit) begin
        err_q <= 1'b1;
      end
      if (state == ST_REQ) tmo_q <= '0;
      else if (state == ST_WAIT && !ks_done) tmo_q <= tmo_q + TW'(1);
    end
  end

  assign busy        = (state != ST_IDLE);
  assign done        = (state == ST_FIN);
  assign ks_ena      = (state == ST_REQ) || (state == ST_WAIT);
  assign ks_round    = round_q;
  assign ks_prev_key = prev_q;
  assign err         = err_q;
  assign keys_ready  = keys_ready_q;

  assign st_we    = start_acc || store;
  assign st_waddr = start_acc ? '0 : round_q;
  assign st_wdata = start_acc ? key_in : ks_next_key;

  aes_rkey_store #(.NR(NR), .KEY_W(KEY_W)) u_store (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (st_we),
    .waddr      (st_waddr),
    .wdata      (st_wdata),
    .keys_ready (keys_ready_q),
    .rd_en      (rd_en),
    .rd_round   (rd_round),
    .rd_key     (rd_key),
    .rd_valid   (rd_valid)
  );

endmodule

// File: tb/tb_aes_key_expand_ctrl.sv
// Bench for aes_key_expand_ctrl: behavioural AES-128 key-schedule step and reference expansion,
// randomized keys and step delays, reads checked against the reference round keys.
module tb_aes_key_expand_ctrl;
  import aes_pkg::*;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         rd_en = 1'b0;
  logic [3:0]   rd_round = 4'd0;
  logic [127:0] key_in = '0;
  logic         ks_done;
  logic [127:0] ks_next_key;
  logic         busy, done, err, ks_ena, rd_valid;
  logic [3:0]   keys_ready, ks_round;
  logic [127:0] ks_prev_key, rd_key;

  always #5 clk = ~clk;

  aes_key_expand_ctrl dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .key_in      (key_in),
    .abort       (abort),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .keys_ready  (keys_ready),
    .ks_ena      (ks_ena),
    .ks_round    (ks_round),
    .ks_prev_key (ks_prev_key),
    .ks_next_key (ks_next_key),
    .ks_done     (ks_done),
    .rd_en       (rd_en),
    .rd_round    (rd_round),
    .rd_key      (rd_key),
    .rd_valid    (rd_valid)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- AES-128 reference key schedule ----------------
  logic [7:0]   sbox [256];
  logic [127:0] exp_rk [11];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  task automatic init_sbox();
    logic [7:0] inv;
    for (int i = 0; i < 256; i++) begin
      inv = 8'h00;
      for (int j = 1; j < 256; j++)
        if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
      sbox[i] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] next_rk(input logic [127:0] p, input int r);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w, rw, t, w0, w1, w2, w3;
    for (int k = 1; k < r; k++) rc = xtime(rc);
    w  = p[31:0];
    rw = {w[23:0], w[31:24]};
    t  = {sbox[rw[31:24]], sbox[rw[23:16]], sbox[rw[15:8]], sbox[rw[7:0]]} ^ {rc, 24'h0};
    w0 = p[127:96] ^ t;
    w1 = p[95:64] ^ w0;
    w2 = p[63:32] ^ w1;
    w3 = w ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  task automatic build(input logic [127:0] key);
    exp_rk[0] = key;
    for (int r = 1; r <= 10; r++) exp_rk[r] = next_rk(exp_rk[r-1], r);
  endtask

  // ---------------- key-schedule step model ----------------
  int           step_delay = 1;
  bit           rand_delay = 1'b0;
  int           hang_round = 0;
  int           cur_delay  = 1;
  int           ena_cnt    = 0;
  int           unstable   = 0;
  int           done_cnt   = 0;
  logic         last_ena   = 1'b0;
  logic [3:0]   last_round = 4'd0;
  logic [127:0] last_prev  = '0;

  always @(posedge clk) begin
    if (ks_ena && last_ena && (ks_round !== last_round || ks_prev_key !== last_prev)) unstable++;
    last_ena   = ks_ena;
    last_round = ks_round;
    last_prev  = ks_prev_key;
    if (done) done_cnt++;
    if (!ks_ena) begin
      ena_cnt   = 0;
      cur_delay = rand_delay ? int'($urandom_range(1, 14)) : step_delay;
      ks_done   <= 1'b0;
    end else begin
      ena_cnt++;
      if (ena_cnt >= cur_delay && int'(ks_round) != hang_round) begin
        ks_done     <= 1'b1;
        ks_next_key <= next_rk(ks_prev_key, int'(ks_round));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic pulse_start(input logic [127:0] k);
    @(negedge clk);
    start  = 1'b1;
    key_in = k;
    @(negedge clk);
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic rd(input int idx, output logic v, output logic [127:0] k);
    @(negedge clk);
    rd_en    = 1'b1;
    rd_round = idx[3:0];
    @(negedge clk);
    v        = rd_valid;
    k        = rd_key;
    rd_en    = 1'b0;
  endtask

  task automatic check_keys(input string tag, input int upto);
    logic         v;
    logic [127:0] k;
    for (int r = 0; r <= upto; r++) begin
      rd(r, v, k);
      chk($sformatf("%s_v%0d", tag, r), 128'(v), 128'(1));
      chk($sformatf("%s_rk%0d", tag, r), k, exp_rk[r]);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int           cyc;
    int           n;
    logic         v;
    logic [127:0] k, ka, kb;

    init_sbox();
    repeat (3) @(negedge clk);
    chk("rst_ctl", 128'({busy, done, err, keys_ready, ks_ena, ks_round, rd_valid}), '0);
    chk("rst_prev", ks_prev_key, '0);
    chk("rst_rdkey", rd_key, '0);
    rst_n = 1'b1;

    // 1: FIPS-197 key, 1-cycle step
    ka = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    build(ka);
    pulse_start(ka);
    chk("t1_busy", 128'(busy), 128'(1));
    wait_done(200, cyc);
    chk("t1_done_cyc", 128'(cyc), 128'(30));
    @(negedge clk);
    chk("t1_idle", 128'({busy, done, err}), '0);
    chk("t1_ready", 128'(keys_ready), 128'(11));
    rd(1, v, k);
    chk("t1_fips_rk1", k, 128'ha0fafe1788542cb123a339392a6c7605);
    rd(10, v, k);
    chk("t1_fips_rk10", k, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
    check_keys("t1", 10);

    // 2: random keys, random per-round step delay
    rand_delay = 1'b1;
    for (int it = 0; it < 3; it++) begin
      ka = {$urandom, $urandom, $urandom, $urandom};
      build(ka);
      unstable = 0;
      pulse_start(ka);
      wait_done(400, cyc);
      chk($sformatf("t2_done%0d", it), 128'(done), 128'(1));
      chk($sformatf("t2_stable%0d", it), 128'(unstable), '0);
      check_keys($sformatf("t2_%0d", it), 10);
    end
    rand_delay = 1'b0;

    // 3: step never completes round 3 -> timeout
    step_delay = 1;
    hang_round = 3;
    n = done_cnt;
    ka = {$urandom, $urandom, $urandom, $urandom};
    build(ka);
    pulse_start(ka);
    cyc = 1;
    while (!err && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    chk("t3_err_cyc", 128'(cyc), 128'(23));
    chk("t3_err", 128'(err), 128'(1));
    chk("t3_busy", 128'(busy), '0);
    chk("t3_ready", 128'(keys_ready), 128'(3));
    chk("t3_nodone", 128'(done_cnt), 128'(n));
    check_keys("t3", 2);
    rd(3, v, k);
    chk("t3_rd3_v", 128'(v), '0);
    hang_round = 0;

    // 4: reads during expansion, out-of-range read; start clears err
    step_delay = 10;
    ka = {$urandom, $urandom, $urandom, $urandom};
    build(ka);
    pulse_start(ka);
    chk("t4_err_clr", 128'(err), '0);
    rd(2, v, k);
    chk("t4_early_v", 128'(v), '0);
    chk("t4_early_k", k, '0);
    n = 0;
    while (keys_ready < 4'd3 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t4_ready3", 128'(keys_ready >= 4'd3), 128'(1));
    rd(2, v, k);
    chk("t4_late_v", 128'(v), 128'(1));
    chk("t4_late_k", k, exp_rk[2]);
    rd(11, v, k);
    chk("t4_rd11_v", 128'(v), '0);
    chk("t4_rd11_k", k, '0);
    wait_done(400, cyc);
    chk("t4_done", 128'(done), 128'(1));
    rd(15, v, k);
    chk("t4_rd15", 128'({v, k}), '0);

    // 5: abort with simultaneous start in round 5, then a clean expansion
    rand_delay = 1'b1;
    n = done_cnt;
    ka = {$urandom, $urandom, $urandom, $urandom};
    pulse_start(ka);
    cyc = 0;
    while (!(ks_ena && ks_round == 4'd5) && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    chk("t5_reach5", 128'(ks_round), 128'(5));
    abort  = 1'b1;
    start  = 1'b1;
    key_in = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    abort  = 1'b0;
    start  = 1'b0;
    chk("t5_abort", 128'({busy, ks_ena, keys_ready}), '0);
    repeat (20) @(negedge clk);
    chk("t5_still_idle", 128'(busy), '0);
    chk("t5_nodone", 128'(done_cnt), 128'(n));
    chk("t5_noerr", 128'(err), '0);
    ka = {$urandom, $urandom, $urandom, $urandom};
    build(ka);
    pulse_start(ka);
    wait_done(400, cyc);
    chk("t5_done", 128'(done), 128'(1));
    check_keys("t5", 10);
    rand_delay = 1'b0;

    // 6: start while busy ignored, then async reset mid-WAIT
    step_delay = 5;
    ka = {$urandom, $urandom, $urandom, $urandom};
    kb = ~ka;
    build(ka);
    pulse_start(ka);
    repeat (6) @(negedge clk);
    start  = 1'b1;
    key_in = kb;
    @(negedge clk);
    start  = 1'b0;
    chk("t6_busy", 128'(busy), 128'(1));
    wait_done(400, cyc);
    chk("t6_done", 128'(done), 128'(1));
    check_keys("t6", 10);

    pulse_start(kb);
    cyc = 0;
    while (!(ks_ena && ks_round == 4'd2) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_arst_ctl", 128'({busy, done, err, keys_ready, ks_ena, ks_round, rd_valid}), '0);
    chk("t6_arst_prev", ks_prev_key, '0);
    chk("t6_arst_rdkey", rd_key, '0);
    @(negedge clk);
    rst_n = 1'b1;
    rd(0, v, k);
    chk("t6_post_rd0", 128'({v, k}), '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
